uart_receiver: RTL and testbench

- Serial-to-parallel UART receiver; the receive-side counterpart of the team's UART transmitter.
- Shares the 16x oversampling tick from the common baud-rate generator.
- Detects the start bit, samples each data bit at its midpoint (LSB first), checks the stop bit, and presents the assembled byte with a one-cycle done strobe.
- Sits between the board RX pin and the UART FIFO/command interface.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_rx_sync.sv | 34 +++
 rtl/uart_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions: FSM state encoding, oversampling
//               constants. Optional macro: UART_RX_PARITY_EN (adds PARITY
//               state and widens the state encoding to 3 bits).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

    // Oversampling ratio of the shared baud tick and the mid-bit sample point
    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;

    // State encoding shared with the transmitter
    localparam int IDLE   = 0;
    localparam int START  = 1;
    localparam int DATA   = 2;
    localparam int STOP   = 3;
    localparam int PARITY = 4;

`ifdef UART_RX_PARITY_EN
    localparam int STATE_W = 3;
`else
    localparam int STATE_W = 2;
`endif

    typedef enum logic [STATE_W-1:0] {
        S_IDLE   = STATE_W'(IDLE),
        S_START  = STATE_W'(START),
        S_DATA   = STATE_W'(DATA),
        S_STOP   = STATE_W'(STOP)
`ifdef UART_RX_PARITY_EN
        ,
        S_PARITY = STATE_W'(PARITY)
`endif
    } state_t;

endpackage

`default_nettype wire

// File: rtl/uart_rx_sync.sv
// ============================================================================
// Module      : uart_rx_sync
// Description : Two-flop synchronizer for an asynchronous single-bit input,
//               with a parameterized reset value (idle level of the line).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic [1:0] sync_ff;

    // Shift the raw input through two flops to settle metastability
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_ff <= {2{RESET_VAL}};
        end else begin
            sync_ff <= {sync_ff[0], din};
        end
    end

    assign dout = sync_ff[1];

endmodule

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================================
// Module      : uart_receiver
// Description : 16x-oversampled UART receiver. Detects the start bit, samples
//               each data bit mid-bit (LSB first), checks the stop bit and
//               presents the byte with a one-cycle rx_done_tick strobe.
//               Optional macro: UART_RX_PARITY_EN (even-parity bit between
//               data and stop, reported on parity_err).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
`ifdef UART_RX_PARITY_EN
    output logic            parity_err,
`endif
    output logic            frame_err
);

    // Tick counter needs a fifth bit only for stop periods longer than a bit
    localparam int             S_W        = (SB_TICK > 16) ? 5 : 4;
    localparam logic [S_W-1:0] S_MID      = S_W'(MID_TICK);
    localparam logic [S_W-1:0] S_BIT_END  = S_W'(OVERSAMPLE - 1);
    localparam logic [S_W-1:0] S_STOP_END = S_W'(SB_TICK - 1);
    localparam logic [2:0]     N_LAST     = 3'(DBIT - 1);

    logic            rx_s;
    state_t          state_reg, state_next;
    logic [S_W-1:0]  s_reg, s_next;
    logic [2:0]      n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [DBIT-1:0] dout_next;
    logic            frame_err_next;
    logic            done_next;
`ifdef UART_RX_PARITY_EN
    logic            pbad_reg, pbad_next;
    logic            parity_err_next;
`endif

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk   (clk),
        .reset (reset),
        .din   (rx),
        .dout  (rx_s)
    );

    // State, counters, shift register and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            s_reg        <= '0;
            n_reg        <= '0;
            b_reg        <= '0;
            dout         <= '0;
            frame_err    <= 1'b0;
            rx_done_tick <= 1'b0;
`ifdef UART_RX_PARITY_EN
            pbad_reg     <= 1'b0;
            parity_err   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            s_reg        <= s_next;
            n_reg        <= n_next;
            b_reg        <= b_next;
            dout         <= dout_next;
            frame_err    <= frame_err_next;
            rx_done_tick <= done_next;
`ifdef UART_RX_PARITY_EN
            pbad_reg     <= pbad_next;
            parity_err   <= parity_err_next;
`endif
        end
    end

    // Next-state logic; everything holds unless a tick (or idle edge) acts
    always_comb begin
        state_next     = state_reg;
        s_next         = s_reg;
        n_next         = n_reg;
        b_next         = b_reg;
        dout_next      = dout;
        frame_err_next = frame_err;
        done_next      = 1'b0;
`ifdef UART_RX_PARITY_EN
        pbad_next       = pbad_reg;
        parity_err_next = parity_err;
`endif
        case (state_reg)
            S_IDLE: begin
                // Falling edge seen at clk rate, not gated by s_tick
                if (!rx_s) begin
                    state_next = S_START;
                    s_next     = '0;
                end
            end
            S_START: begin
                if (s_tick) begin
                    if (s_reg == S_MID) begin
                        // Line back high mid start bit: reject as a glitch
                        if (!rx_s) begin
                            state_next = S_DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            S_DATA: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_END) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_next = S_PARITY;
`else
                            state_next = S_STOP;
`endif
                        end else begin
                            n_next = n_reg + 3'd1;
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_BIT_END) begin
                        // Even parity: odd count of ones over data+parity is bad
                        s_next     = '0;
                        pbad_next  = ^{rx_s, b_reg};
                        state_next = S_STOP;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                if (s_tick) begin
                    if (s_reg == S_STOP_END) begin
                        state_next     = S_IDLE;
                        done_next      = 1'b1;
                        dout_next      = b_reg;
                        frame_err_next = ~rx_s;
`ifdef UART_RX_PARITY_EN
                        parity_err_next = pbad_reg;
`endif
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_receiver.sv
// ============================================================================
// Module      : tb_uart_receiver
// Description : Scoreboard bench for uart_receiver: serial frames are driven
//               bit by bit, expected words are queued at send time and a
//               monitor compares them whenever rx_done_tick fires.
//               Honours UART_RX_PARITY_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_receiver;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_RX_PARITY_EN
    localparam int PAR_TICKS = 16;
`else
    localparam int PAR_TICKS = 0;
`endif
    // Full line time of one frame, and the nominal strobe point (mid stop bit)
    localparam int FRAME_TICKS    = 16 + 16 * DBIT + PAR_TICKS + SB_TICK;
    localparam int MID_STOP_TICKS = FRAME_TICKS - 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            rx;
    logic            s_tick;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
`ifdef UART_RX_PARITY_EN
    logic            parity_err;
`endif

    uart_receiver #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
`ifdef UART_RX_PARITY_EN
        .parity_err   (parity_err),
`endif
        .frame_err    (frame_err)
    );

    typedef struct {
        logic [DBIT-1:0] data;
        logic            ferr;
        logic            perr;
        longint          t0;
    } exp_t;

    exp_t            sb_q[$];
    int              vectors     = 0;
    int              miscompares = 0;
    longint          tick_cnt    = 0;
    int              done_cnt    = 0;
    logic [DBIT-1:0] last_dout   = '0;
    logic            last_ferr   = 1'b0;

    always #5 clk = ~clk;

    // Count baud ticks as the DUT sees them
    always @(posedge clk) if (s_tick) tick_cnt <= tick_cnt + 1;

    // 16x baud tick: one clk high every 4 clk
    initial begin
        s_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            s_tick = 1'b1;
            @(negedge clk);
            s_tick = 1'b0;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, queue depth %0d, expected 0", sb_q.size());
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait for n ticks, returning on the negedge just after the last one
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (s_tick !== 1'b1) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(16);
    endtask

    // One frame. A bad stop bit is low across its midpoint and recovers for
    // the last quarter, so the receiver re-syncs cleanly on the next frame.
    task automatic send_frame(input logic [DBIT-1:0] data, input logic stop_ok, input logic par_ok);
        exp_t e;
        e.data = data;
        e.ferr = ~stop_ok;
`ifdef UART_RX_PARITY_EN
        e.perr = ~par_ok;
`else
        e.perr = 1'b0;
`endif
        e.t0   = tick_cnt;
        sb_q.push_back(e);
        send_bit(1'b0);
        for (int i = 0; i < DBIT; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
        send_bit((^data) ^ ~par_ok);
`endif
        if (stop_ok) begin
            send_bit(1'b1);
        end else begin
            rx = 1'b0;
            wait_ticks(12);
            rx = 1'b1;
            wait_ticks(4);
        end
    endtask

    task automatic idle(input int bits);
        rx = 1'b1;
        wait_ticks(16 * bits);
    endtask

    // Monitor: every strobe must match the oldest outstanding frame
    always @(negedge clk) begin
        if (!reset && rx_done_tick === 1'b1) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_strobe: got strobe with dout %0h, expected none", dout);
            end else begin
                exp_t   e;
                longint lat;
                e = sb_q.pop_front();
                check("dout", 64'(dout), 64'(e.data));
                check("frame_err", 64'(frame_err), 64'(e.ferr));
`ifdef UART_RX_PARITY_EN
                check("parity_err", 64'(parity_err), 64'(e.perr));
`endif
                lat = tick_cnt - e.t0;
                vectors++;
                if (lat < MID_STOP_TICKS - 1 || lat > FRAME_TICKS + 1) begin
                    miscompares++;
                    $display("FAIL latency: got %0d ticks, expected %0d..%0d", lat, MID_STOP_TICKS - 1, FRAME_TICKS + 1);
                end
                last_dout = e.data;
                last_ferr = e.ferr;
            end
        end
    end

    initial begin
        int              d0;
        int              gap;
        logic [DBIT-1:0] rd;
        logic [DBIT-1:0] partial;
        logic            sok;
        logic            pok;

        rx    = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_dout", 64'(dout), 64'h0);
        check("reset_frame_err", 64'(frame_err), 64'h0);
        check("reset_done", 64'(rx_done_tick), 64'h0);
`ifdef UART_RX_PARITY_EN
        check("reset_parity_err", 64'(parity_err), 64'h0);
`endif
        reset = 1'b0;
        wait_ticks(4);

        // Good frame
        send_frame(8'hA5, 1'b1, 1'b1);
        idle(2);

        // Framing error, then recovery
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(2);
        send_frame(8'h01, 1'b1, 1'b1);
        idle(2);

        // Short low glitch must be rejected
        d0 = done_cnt;
        rx = 1'b0;
        wait_ticks(3);
        idle(3);
        check("glitch_no_strobe", 64'(done_cnt), 64'(d0));
        check("glitch_dout_held", 64'(dout), 64'(last_dout));
        check("glitch_ferr_held", 64'(frame_err), 64'(last_ferr));

        // Back-to-back frames, no idle gap
        d0 = done_cnt;
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(2);
        check("b2b_strobes", 64'(done_cnt), 64'(d0 + 2));

        // Leave frame_err set so the reset has something to clear
        send_frame(8'h96, 1'b0, 1'b1);
        idle(2);

        // Reset in the middle of data bit 4 of 0x81
        d0      = done_cnt;
        partial = 8'h81;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(partial[i]);
        rx = partial[4];
        wait_ticks(8);
        reset = 1'b1;
        #1;
        check("midreset_dout", 64'(dout), 64'h0);
        check("midreset_frame_err", 64'(frame_err), 64'h0);
        check("midreset_done", 64'(rx_done_tick), 64'h0);
        last_dout = '0;
        last_ferr = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        idle(12);
        check("midreset_no_strobe", 64'(done_cnt), 64'(d0));
        send_frame(8'h81, 1'b1, 1'b1);
        idle(2);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle(1);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(1);
`endif

        // Randomized frames, gaps and error injection
        for (int k = 0; k < 12; k++) begin
            rd  = DBIT'($urandom);
            sok = ($urandom_range(0, 3) != 0);
            pok = ($urandom_range(0, 3) != 0);
            send_frame(rd, sok, pok);
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
        end
        idle(2);

        for (int w = 0; w < 4000 && sb_q.size() != 0; w++) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
